// File: rtl/inst_prefetch_buf.sv
// Decoupled instruction fetch engine: issues sequential word fetches under a
// ren/ack handshake and queues fetched {pc, instruction} pairs for the ID stage.
module inst_prefetch_buf #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    inst_ren,
  output logic [ADDR_WIDTH-1:0]   inst_addr,
  input  logic [DATA_WIDTH-1:0]   inst_data,
  input  logic                    inst_ack,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    if_valid,
  output logic [DATA_WIDTH-1:0]   if_inst,
  output logic [ADDR_WIDTH-1:0]   if_pc,
  input  logic                    id_en,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int             PW   = $clog2(DEPTH);
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t                  state_q, state_d;
  logic                    ren_q, ren_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   pend_q, pend_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           head_q, head_d;
  logic [PW-1:0]           tail_q, tail_d;
  logic                    push, pop;

  logic [ADDR_WIDTH-1:0]   mem_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_inst_q [DEPTH];

  assign push = (state_q == REQ) && inst_ack && !redirect;
  assign pop  = (cnt_q != '0) && id_en && !redirect;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
      pend_d = redirect_pc;
    end else begin
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      head_d = head_q + PW'(pop);
      tail_d = tail_q + PW'(push);
    end
    // One slot stays reserved for the outstanding request, so a push never overflows.
    ren_d = (cnt_d < FULL);
    if (redirect && ren_q && !inst_ack) begin
      state_d = DROP;
      ren_d   = 1'b1;
    end else if (redirect) begin
      state_d = REQ;
      addr_d  = redirect_pc;
    end else begin
      case (state_q)
        IDLE: state_d = ren_d ? REQ : IDLE;
        REQ: begin
          if (inst_ack) addr_d = addr_q + ADDR_WIDTH'(4);
          state_d = ren_d ? REQ : IDLE;
        end
        DROP: begin
          if (inst_ack) begin
            addr_d  = pend_q;
            state_d = ren_d ? REQ : IDLE;
          end else begin
            state_d = DROP;
            ren_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage carries no reset; visibility is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[tail_q]   <= addr_q;
      mem_inst_q[tail_q] <= inst_data;
    end
  end

  assign inst_ren  = ren_q;
  assign inst_addr = addr_q;
  assign count     = cnt_q;
  assign if_valid  = (cnt_q != '0);
  assign if_inst   = if_valid ? mem_inst_q[head_q] : '0;
  assign if_pc     = if_valid ? mem_pc_q[head_q]   : '0;

endmodule
